// File: rtl/mem_arbiter.sv
// Round-robin arbiter from NUM_DEV requester channels onto one tagged memory port; routes answers back by tag.
// Optional MEM_ARB_ERR_EN adds a sticky err_orphan flag for answers whose tag has no recorded owner.
module mem_arbiter #(
  parameter int unsigned NUM_DEV = 2,
  parameter int unsigned BLK_W   = 64,
  parameter int unsigned IDX_W   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2*NUM_DEV-1:0]       dev_qry_cmd,
  input  logic [BLK_W*NUM_DEV-1:0]   dev_qry_blk,
  input  logic [IDX_W*NUM_DEV-1:0]   dev_qry_idx,
  output logic [TAG_W*NUM_DEV-1:0]   dev_ack,
  output logic [BLK_W*NUM_DEV-1:0]   dev_ans_blk,
  output logic [TAG_W*NUM_DEV-1:0]   dev_ans_tag,
  output logic [1:0]                 mem_qry_cmd,
  output logic [BLK_W-1:0]           mem_qry_blk,
  output logic [IDX_W-1:0]           mem_qry_idx,
  input  logic [TAG_W-1:0]           mem_ack,
  input  logic [BLK_W-1:0]           mem_ans_blk,
  input  logic [TAG_W-1:0]           mem_ans_tag
`ifdef MEM_ARB_ERR_EN
  ,
  output logic                       err_orphan
`endif
);

  localparam int unsigned CH_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NTAG  = 1 << TAG_W;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_LOAD  = 2'd1,
    CMD_STORE = 2'd2,
    CMD_RSVD  = 2'd3
  } cmd_e;

  typedef logic [CH_W-1:0] ch_t;

  function automatic ch_t rr_ch(input ch_t base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    return ch_t'(s % NUM_DEV);
  endfunction

  ch_t                rr_q, rr_d;
  logic [NTAG-1:0]    own_vld_q, own_vld_d;
  ch_t                own_ch_q [NTAG];
  ch_t                own_ch_d [NTAG];
  logic [CNT_W-1:0]   cnt_q [NUM_DEV];
  logic [CNT_W-1:0]   cnt_d [NUM_DEV];

  logic [NUM_DEV-1:0] elig;
  logic               gnt_vld;
  ch_t                gnt_ch;
  cmd_e               gnt_cmd;
  logic               accept;
  logic               ans_hit;
  ch_t                ans_ch;

  always_comb begin
    for (int unsigned c = 0; c < NUM_DEV; c++) begin
      elig[c] = ((cmd_e'(dev_qry_cmd[2*c +: 2]) == CMD_LOAD) && (cnt_q[c] < CNT_W'(MAX_OUT))) ||
                (cmd_e'(dev_qry_cmd[2*c +: 2]) == CMD_STORE);
    end
  end

  // First eligible channel scanning upward from rr_q; nothing is granted while reset is high.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (!gnt_vld && !reset && elig[rr_ch(rr_q, i)]) begin
        gnt_vld = 1'b1;
        gnt_ch  = rr_ch(rr_q, i);
      end
    end
  end

  always_comb begin
    gnt_cmd     = CMD_NONE;
    mem_qry_blk = '0;
    mem_qry_idx = '0;
    dev_ack     = '0;
    for (int unsigned c = 0; c < NUM_DEV; c++) begin
      if (gnt_vld && (gnt_ch == ch_t'(c))) begin
        gnt_cmd                = cmd_e'(dev_qry_cmd[2*c +: 2]);
        mem_qry_blk            = dev_qry_blk[BLK_W*c +: BLK_W];
        mem_qry_idx            = dev_qry_idx[IDX_W*c +: IDX_W];
        dev_ack[TAG_W*c +: TAG_W] = mem_ack;
      end
    end
    mem_qry_cmd = gnt_cmd;
  end

  assign accept  = gnt_vld && (mem_ack != '0);
  assign ans_hit = !reset && (mem_ans_tag != '0) && own_vld_q[mem_ans_tag];
  assign ans_ch  = own_ch_q[mem_ans_tag];

  always_comb begin
    dev_ans_blk = '0;
    dev_ans_tag = '0;
    for (int unsigned c = 0; c < NUM_DEV; c++) begin
      if (ans_hit && (ans_ch == ch_t'(c))) begin
        dev_ans_blk[BLK_W*c +: BLK_W] = mem_ans_blk;
        dev_ans_tag[TAG_W*c +: TAG_W] = mem_ans_tag;
      end
    end
  end

  // Answer frees its entry before the accept writes, so a same-tag accept in the same cycle wins.
  always_comb begin
    rr_d      = rr_q;
    own_vld_d = own_vld_q;
    own_ch_d  = own_ch_q;
    if (accept) rr_d = rr_ch(gnt_ch, 1);
    if (ans_hit) own_vld_d[mem_ans_tag] = 1'b0;
    if (accept && (gnt_cmd == CMD_LOAD)) begin
      own_vld_d[mem_ack] = 1'b1;
      own_ch_d[mem_ack]  = gnt_ch;
    end
    for (int unsigned c = 0; c < NUM_DEV; c++) begin
      cnt_d[c] = cnt_q[c];
      if (accept && (gnt_cmd == CMD_LOAD) && (gnt_ch == ch_t'(c))) begin
        if (!(ans_hit && (ans_ch == ch_t'(c)))) cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (ans_hit && (ans_ch == ch_t'(c))) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q      <= '0;
      own_vld_q <= '0;
      for (int unsigned c = 0; c < NUM_DEV; c++) cnt_q[c] <= '0;
    end else begin
      rr_q      <= rr_d;
      own_vld_q <= own_vld_d;
      own_ch_q  <= own_ch_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef MEM_ARB_ERR_EN
  logic orphan;
  assign orphan = !reset && (mem_ans_tag != '0) && !own_vld_q[mem_ans_tag];

  always_ff @(posedge clock) begin
    if (reset)       err_orphan <= 1'b0;
    else if (orphan) err_orphan <= 1'b1;
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_DEV, default 2, number of requester channels (1..8).
REQ-002 Parameter BLK_W, default 64, data block width in bits.
REQ-003 Parameter IDX_W, default 32, block index width in bits.
REQ-004 Parameter TAG_W, default 4, transaction tag width; tag 0 means "none".
REQ-005 Parameter MAX_OUT, default 4, maximum outstanding loads per channel (1..15).
REQ-006 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-007 Port reset  in  1  synchronous, active-high reset.
REQ-008 Port dev_qry_cmd  in  2*NUM_DEV  per-channel command: 0 NONE, 1 LOAD, 2 STORE, 3 reserved (treated as NONE).
REQ-009 Port dev_qry_blk  in  BLK_W*NUM_DEV  per-channel store data.
REQ-010 Port dev_qry_idx  in  IDX_W*NUM_DEV  per-channel block index.
REQ-011 Port dev_ack  out  TAG_W*NUM_DEV  per-channel accept tag; nonzero = request accepted this cycle.
REQ-012 Port dev_ans_blk  out  BLK_W*NUM_DEV  per-channel load data.
REQ-013 Port dev_ans_tag  out  TAG_W*NUM_DEV  per-channel answer tag; nonzero = dev_ans_blk valid this cycle.
REQ-014 Ports mem_qry_cmd/mem_qry_blk/mem_qry_idx  out  2/BLK_W/IDX_W  downstream request.
REQ-015 Ports mem_ack/mem_ans_blk/mem_ans_tag  in  TAG_W/BLK_W/TAG_W  downstream accept and answer, same encoding.
REQ-016 Port err_orphan  out  1  sticky flag for answers with no recorded owner (present only with MEM_ARB_ERR_EN).

Function
REQ-017 A channel is eligible when its command is LOAD or STORE and, for LOAD, its outstanding count < MAX_OUT; STORE is never blocked by the count.
REQ-018 Grant selects one eligible channel per cycle by round-robin starting at pointer rr_ptr; combinational.
REQ-019 Granted channel's cmd/blk/idx drive mem_qry_* the same cycle; with no grant mem_qry_cmd = NONE, blk/idx = 0.
REQ-020 mem_ack is routed to the granted channel's dev_ack the same cycle; all other dev_ack = 0.
REQ-021 Accept = grant with mem_ack != 0; on accept rr_ptr <= (granted+1) mod NUM_DEV; without accept rr_ptr holds, so the grant is retained while the request is held.
REQ-022 Accepted LOAD: owner table entry [mem_ack] <= {valid=1, channel}, channel outstanding +1; accepted STORE records nothing.
REQ-023 mem_ans_tag != 0 with valid owner entry: dev_ans_blk/dev_ans_tag of the owner driven same cycle, entry invalidated, owner outstanding -1; other channels' dev_ans_tag = 0, dev_ans_blk = 0.
REQ-024 Answer and LOAD accept on same channel, same cycle: outstanding count unchanged.
REQ-025 Answer and accept carrying the same tag, same cycle: answer consumes the old entry, accept writes the new entry (write wins).
REQ-026 Answer with tag 0 is ignored; answer with no valid owner is dropped, no dev output asserted.
REQ-027 Outstanding counter never wraps; accepts are blocked at MAX_OUT per REQ-017.

Reset
REQ-028 On reset: rr_ptr = 0, all owner entries invalid, all outstanding counts 0, err_orphan = 0.
REQ-029 Outputs are combinational from registered state and inputs; while reset is high dev_ack, dev_ans_tag, mem_qry_cmd are 0 and no state updates except clearing.
REQ-030 Answers arriving after reset for pre-reset tags are treated as orphans.

Configuration
REQ-031 Macro MEM_ARB_ERR_EN defined: err_orphan port exists, set on any orphan answer, cleared only by reset.
REQ-032 Macro MEM_ARB_ERR_EN undefined: port absent, orphans silently dropped, all other behaviour identical.

Verification
REQ-033 Ch0 and ch1 LOAD continuously, mem_ack=1,2,3,4 on four cycles -> grants alternate ch0,ch1,ch0,ch1; dev_ack tags 1,3 on ch0 and 2,4 on ch1.
REQ-034 Ch0 LOAD idx 0x40, mem_ack=0 for 3 cycles then 5 -> mem_qry_idx=0x40 held all 4 cycles, ch0 sees ack 5 on 4th cycle only.
REQ-035 Ch1 accepts 4 LOADs (MAX_OUT=4) unanswered -> ch1 excluded, ch0 LOAD granted; mem_ans_tag for one ch1 tag -> ch1 eligible next cycle.
REQ-036 Tag 7 owned by ch1, mem_ans_tag=7 blk=0xDEAD -> dev_ans_tag[1]=7, dev_ans_blk[1]=0xDEAD, dev_ans_tag[0]=0; repeat mem_ans_tag=7 -> dropped, err_orphan=1 (with MEM_ARB_ERR_EN).
REQ-037 Ch0 STORE accepted tag 3, then mem_ans_tag=3 -> orphan, no channel answered, ch0 outstanding stays 0.
REQ-038 Reset asserted with 2 loads outstanding, then answers for those tags -> both dropped as orphans, rr_ptr=0, counts 0.
